// File: rtl/rvcpu_pkg.sv
// Shared definitions for the rvcpu system-control block: register offsets,
// control FSM states and STATUS register bit positions.
package rvcpu_pkg;

    localparam logic [1:0] SYSCTL_TXDATA = 2'd0;
    localparam logic [1:0] SYSCTL_STATUS = 2'd1;
    localparam logic [1:0] SYSCTL_HALT   = 2'd2;
    localparam logic [1:0] SYSCTL_CYCLE  = 2'd3;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDrain  = 2'd1,
        StHalted = 2'd2
    } sysctl_state_t;

    localparam int unsigned STATUS_FULL_BIT  = 0;
    localparam int unsigned STATUS_EMPTY_BIT = 1;
    localparam int unsigned STATUS_LVL_LSB   = 8;
    localparam int unsigned STATUS_HALT_BIT  = 31;

endpackage

// File: rtl/rvcpu_sync_fifo.sv
// Single-clock circular FIFO; pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate counter.
module rvcpu_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign level_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/rvcpu_sysctl.sv
// System-control and console peripheral: buffered TX byte stream, halt with
// exit code after the console drains, and a free-running cycle counter.
module rvcpu_sysctl
    import rvcpu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [3:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        halted,
    output logic [31:0] exit_code
);

    sysctl_state_t state_q, state_d;
    logic [31:0]   exit_code_q, exit_code_d;
    logic [31:0]   cycle_q, cycle_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;

    logic [1:0]       sel;
    logic             wr_acc, rd_acc, push, pop;
    logic             fifo_full, fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic [31:0]      status_w;
    logic             unused_addr;

    assign sel         = req_addr[3:2];
    assign unused_addr = ^req_addr[1:0];

    // Only a TXDATA push that would actually be queued can stall the bus.
    assign req_ready = !(req_valid && req_we && (sel == SYSCTL_TXDATA) &&
                         (state_q == StRun) && fifo_full);
    assign wr_acc    = req_valid && req_ready && req_we;
    assign rd_acc    = req_valid && req_ready && !req_we;
    assign push      = wr_acc && (sel == SYSCTL_TXDATA) && (state_q == StRun);
    assign pop       = tx_valid && tx_ready;
    assign tx_valid  = !fifo_empty;

    rvcpu_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (req_wdata[7:0]),
        .pop_i   (pop),
        .rdata_o (tx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        status_w                            = '0;
        status_w[STATUS_FULL_BIT]           = fifo_full;
        status_w[STATUS_EMPTY_BIT]          = fifo_empty;
        status_w[STATUS_LVL_LSB +: LVL_W]   = fifo_level;
        status_w[STATUS_HALT_BIT]           = (state_q != StRun);
    end

    always_comb begin
        state_d     = state_q;
        exit_code_d = exit_code_q;
        case (state_q)
            StRun: begin
                if (wr_acc && (sel == SYSCTL_HALT)) begin
                    state_d     = StDrain;
                    exit_code_d = req_wdata;
                end
            end
            StDrain:  if (fifo_empty) state_d = StHalted;
            StHalted: state_d = StHalted;
            default:  state_d = StRun;
        endcase
    end

    always_comb begin
        cycle_d     = (state_q == StHalted) ? cycle_q : cycle_q + 32'd1;
        rsp_valid_d = rd_acc;
        rsp_rdata_d = '0;
        if (rd_acc) begin
            case (sel)
                SYSCTL_TXDATA: rsp_rdata_d = '0;
                SYSCTL_STATUS: rsp_rdata_d = status_w;
                SYSCTL_HALT:   rsp_rdata_d = exit_code_q;
                default:       rsp_rdata_d = cycle_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            exit_code_q <= '0;
            cycle_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            exit_code_q <= exit_code_d;
            cycle_q     <= cycle_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign halted    = (state_q == StHalted);
    assign exit_code = exit_code_q;

endmodule

// File: tb/tb_rvcpu_sysctl.sv
// Directed self-checking bench for rvcpu_sysctl.
module tb_rvcpu_sysctl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        halted;
    logic [31:0] exit_code;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [3:0] A_TX     = 4'h0;
    localparam logic [3:0] A_STATUS = 4'h4;
    localparam logic [3:0] A_HALT   = 4'h8;
    localparam logic [3:0] A_CYCLE  = 4'hC;

    rvcpu_sysctl #(
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .halted    (halted),
        .exit_code (exit_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic v, output logic [31:0] d);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        tick();
        req_valid = 1'b0;
        v = rsp_valid;
        d = rsp_rdata;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        tx_ready  = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        logic        v;
        logic [31:0] d;
        do_reset();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin n_fail++;
            $display("FAIL reset_rsp: got %b/%h want 0/0", rsp_valid, rsp_rdata); end
        n_checks++; if (tx_valid !== 1'b0 || halted !== 1'b0) begin n_fail++;
            $display("FAIL reset_tx_halt: got %b/%b want 0/0", tx_valid, halted); end
        n_checks++; if (exit_code !== 32'h0) begin n_fail++;
            $display("FAIL reset_exit_code: got %h want 0", exit_code); end
        rst_n = 1'b1;
        bus_read(A_CYCLE, v, d);
        n_checks++; if (v !== 1'b1 || d !== 32'h0) begin n_fail++;
            $display("FAIL reset_cycle: got %b/%h want 1/00000000", v, d); end
        bus_read(A_STATUS, v, d);
        n_checks++; if (v !== 1'b1 || d !== 32'h0000_0002) begin n_fail++;
            $display("FAIL reset_status: got %b/%h want 1/00000002", v, d); end
        tick();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++;
            $display("FAIL rsp_one_cycle: got %b want 0", rsp_valid); end
        bus_write(A_STATUS, 32'hFFFF_FFFF);
        bus_read(A_STATUS, v, d);
        n_checks++; if (d !== 32'h0000_0002) begin n_fail++;
            $display("FAIL ro_write_ignored: got %h want 00000002", d); end
    endtask

    task automatic test_stream();
        tx_ready  = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = A_TX;
        req_wdata = 32'h48;
        tick();
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h48) begin n_fail++;
            $display("FAIL stream_first: got %b/%h want 1/48", tx_valid, tx_data); end
        req_wdata = 32'h69;
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h69) begin n_fail++;
            $display("FAIL stream_second: got %b/%h want 1/69", tx_valid, tx_data); end
        tick();
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++;
            $display("FAIL stream_empty: got %b want 0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_full_stall();
        logic        v;
        logic [31:0] d;
        logic [7:0]  exp;
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) bus_write(A_TX, 32'h10 + i);
        bus_read(A_STATUS, v, d);
        n_checks++; if (d !== 32'h0000_0801) begin n_fail++;
            $display("FAIL full_status: got %h want 00000801", d); end
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = A_TX;
        req_wdata = 32'h99;
        #1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++;
            $display("FAIL full_stall: got req_ready %b want 0", req_ready); end
        tx_ready = 1'b1;
        tick();
        n_checks++; if (req_ready !== 1'b1 || tx_data !== 8'h11) begin n_fail++;
            $display("FAIL stall_clear: got %b/%h want 1/11", req_ready, tx_data); end
        tx_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
        bus_read(A_STATUS, v, d);
        n_checks++; if (d !== 32'h0000_0801) begin n_fail++;
            $display("FAIL refill_status: got %h want 00000801", d); end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = (i < 7) ? 8'(8'h11 + i) : 8'h99;
            n_checks++; if (tx_valid !== 1'b1 || tx_data !== exp) begin n_fail++;
                $display("FAIL drain_byte%0d: got %b/%h want 1/%h", i, tx_valid, tx_data, exp); end
            tick();
        end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++;
            $display("FAIL drain_done: got tx_valid %b want 0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_cycle();
        logic        v;
        logic [31:0] c1, c2;
        bus_read(A_CYCLE, v, c1);
        repeat (9) tick();
        bus_read(A_CYCLE, v, c2);
        n_checks++; if (c2 - c1 !== 32'd10) begin n_fail++;
            $display("FAIL cycle_delta: got %0d want 10", c2 - c1); end
    endtask

    task automatic test_halt();
        logic        v;
        logic [31:0] d, c1, c2;
        tx_ready = 1'b0;
        bus_write(A_TX, 32'hA1);
        bus_write(A_TX, 32'hA2);
        bus_write(A_TX, 32'hA3);
        bus_write(A_HALT, 32'h2A);
        n_checks++; if (exit_code !== 32'h2A || halted !== 1'b0) begin n_fail++;
            $display("FAIL halt_latch: got %h/%b want 0000002a/0", exit_code, halted); end
        bus_read(A_STATUS, v, d);
        n_checks++; if (d !== 32'h8000_0300) begin n_fail++;
            $display("FAIL drain_status: got %h want 80000300", d); end
        bus_write(A_HALT, 32'h55);
        bus_write(A_TX, 32'hEE);
        repeat (3) tick();
        n_checks++; if (exit_code !== 32'h2A || halted !== 1'b0) begin n_fail++;
            $display("FAIL halt_hold: got %h/%b want 0000002a/0", exit_code, halted); end
        tx_ready = 1'b1;
        #1;
        n_checks++; if (tx_data !== 8'hA1) begin n_fail++;
            $display("FAIL drain_a1: got %h want a1", tx_data); end
        tick();
        n_checks++; if (tx_data !== 8'hA2) begin n_fail++;
            $display("FAIL drain_a2: got %h want a2", tx_data); end
        tick();
        n_checks++; if (tx_data !== 8'hA3) begin n_fail++;
            $display("FAIL drain_a3: got %h want a3", tx_data); end
        tick();
        n_checks++; if (tx_valid !== 1'b0 || halted !== 1'b0) begin n_fail++;
            $display("FAIL drained_not_halted: got %b/%b want 0/0", tx_valid, halted); end
        tick();
        n_checks++; if (halted !== 1'b1) begin n_fail++;
            $display("FAIL halted_rise: got %b want 1", halted); end
        bus_read(A_HALT, v, d);
        n_checks++; if (v !== 1'b1 || d !== 32'h2A) begin n_fail++;
            $display("FAIL halt_read: got %b/%h want 1/0000002a", v, d); end
        bus_read(A_STATUS, v, d);
        n_checks++; if (d !== 32'h8000_0002) begin n_fail++;
            $display("FAIL halted_status: got %h want 80000002", d); end
        bus_read(A_CYCLE, v, c1);
        repeat (5) tick();
        bus_read(A_CYCLE, v, c2);
        n_checks++; if (c1 !== c2) begin n_fail++;
            $display("FAIL cycle_frozen: got %h vs %h want equal", c1, c2); end
        tx_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        logic        v;
        logic [31:0] d;
        do_reset();
        rst_n = 1'b1;
        bus_write(A_TX, 32'h31);
        bus_write(A_TX, 32'h32);
        bus_write(A_HALT, 32'h77);
        n_checks++; if (exit_code !== 32'h77 || tx_valid !== 1'b1) begin n_fail++;
            $display("FAIL pre_reset: got %h/%b want 00000077/1", exit_code, tx_valid); end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (tx_valid !== 1'b0 || exit_code !== 32'h0) begin n_fail++;
            $display("FAIL async_reset: got %b/%h want 0/00000000", tx_valid, exit_code); end
        tick();
        rst_n = 1'b1;
        bus_read(A_STATUS, v, d);
        n_checks++; if (d !== 32'h0000_0002 || halted !== 1'b0) begin n_fail++;
            $display("FAIL reset_to_run: got %h/%b want 00000002/0", d, halted); end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        tx_ready  = 1'b0;
        test_reset();
        test_stream();
        test_full_stall();
        test_cycle();
        test_halt();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rvcpu_sysctl.md
# rvcpu_sysctl

System-control and console peripheral on the `rvcpu_top` data bus, placed between the CPU core's load/store port and the simulation harness. Byte stores to a TX register are buffered in a FIFO and streamed out over a valid/ready port. A store to a HALT register latches an exit code, drains the FIFO, then asserts `halted`; the testbench waits on `halted` to end simulation. A free-running cycle counter is also readable.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, ≥2.
- `LVL_W`, $clog2(FIFO_DEPTH)+1: FIFO level width.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  bus request; top-level address decode has already selected this device.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  4  byte offset; only [3:2] is decoded.
- `req_wdata`  in  32  write data.
- `req_ready`  out  1  request accepted this cycle (handshake `req_valid && req_ready`).
- `rsp_valid`  out  1  read data valid.
- `rsp_rdata`  out  32  read data.
- `tx_valid`  out  1  console byte available.
- `tx_data`  out  8  console byte.
- `tx_ready`  in  1  sink accepts byte.
- `halted`  out  1  program finished, FIFO drained.
- `exit_code`  out  32  value written to HALT.

## Operation
- Register map (offset[3:2]):
  - 0 TXDATA: write pushes `wdata[7:0]`; read returns 0.
  - 1 STATUS: read-only. Bit0 = full, bit1 = empty, bits[8+:LVL_W] = level, bit31 = halt pending/done.
  - 2 HALT: write latches `exit_code`; read returns `exit_code`.
  - 3 CYCLE: read-only 32-bit cycle counter. Increments every cycle outside HALTED and wraps 0xFFFF_FFFF→0.
- Writes to read-only registers are accepted and ignored.
- FSM states:
  - RUN: normal operation.
  - DRAIN: entered on an accepted HALT write in RUN. TXDATA writes are accepted and dropped; further HALT writes are ignored (first exit code wins).
  - HALTED: entered from DRAIN when the FIFO is empty. Terminal until reset.
- FIFO: circular buffer with read/write pointers one bit wider than the index, used for full/empty. A push and a pop in the same cycle leave the level unchanged.
- A push to a full FIFO is not dropped. It stalls via `req_ready`=0.
- `tx_valid` = FIFO not empty, in any state. `tx_data` = head entry. Pop on `tx_valid && tx_ready`.

## Timing
- Reset values:
  - `req_ready`=1 except under stall; `rsp_valid`=0, `rsp_rdata`=0.
  - `tx_valid`=0, `halted`=0, `exit_code`=0.
  - Cycle counter 0, FIFO empty, state RUN.
- `req_ready` is combinational: 0 only when `req_valid && req_we`, offset = TXDATA, state = RUN and FIFO full. Otherwise 1.
- A full FIFO with a concurrent pop still stalls; the write is accepted the next cycle.
- Read latency 1: a read accepted in cycle N gives `rsp_valid`=1 with data in N+1, for one cycle. Writes produce no response.
- STATUS and CYCLE return values as of cycle N (pre-update).
- Push latency: a byte accepted in cycle N is visible on `tx_valid`/`tx_data` in N+1.
- A HALT write in cycle N with an empty FIFO: DRAIN in N+1, `halted`=1 in N+2. `exit_code` updates in N+1.
- `halted` is registered and stays 1 until reset. The counter freezes on the cycle `halted` rises.
- Asynchronous reset mid-DRAIN discards FIFO contents and the exit code immediately.

## Structure
- Shared package `rvcpu_pkg`:
  - register offset constants `SYSCTL_TXDATA`/`STATUS`/`HALT`/`CYCLE`;
  - FSM state enum `sysctl_state_t`;
  - STATUS bit positions.
- One sub-module `rvcpu_sync_fifo` (params WIDTH, DEPTH; push/pop/full/empty/level), reusable elsewhere. FSM, decode and counter stay in `rvcpu_sysctl`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles → all outputs at reset values. A STATUS read after reset → `rsp_rdata`=0x0000_0002 (empty).
- Stream: `tx_ready`=1, write 0x48, 0x69 to TXDATA on consecutive cycles → `tx_data` 0x48 then 0x69, each one cycle after acceptance.
- Full/stall: `tx_ready`=0, write 9 bytes with DEPTH=8 → 9th write sees `req_ready`=0. STATUS (read before the stall) shows level 8, full=1. Raise `tx_ready` → stall clears the next cycle and the 9th byte is accepted.
- Drain/halt: 3 bytes queued, `tx_ready`=0, write HALT 0x2A → `halted` stays 0, then `tx_ready`=1 → `halted`=1 the cycle after the FIFO empties; `exit_code`=0x2A. A second HALT 0x55 is ignored.
- Cycle counter: two CYCLE reads 10 cycles apart differ by 10. After `halted`, two reads return equal values.
- Async reset in DRAIN: deassert `rst_n` mid-cycle → `tx_valid`=0 and `exit_code`=0 immediately. State returns to RUN.
